soc_reset_sequencer: RTL

SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

---
 rtl/niosv_rst_seq_pkg.sv | 19 +
 rtl/rst_seq_sync2.sv | 24 ++
 rtl/soc_reset_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/niosv_rst_seq_pkg.sv
// Shared types and default timing constants for the SoC reset / PLL lock sequencer.
package niosv_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_POR_HOLD  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_RETRY     = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_e;

   localparam int unsigned DEF_POR_CYCLES          = 128;
   localparam int unsigned DEF_ARESET_CYCLES       = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer, cleared asynchronously; also used as the reset release synchronizer.
module rst_seq_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/soc_reset_sequencer.sv
// PLL bring-up and SoC reset sequencer: holds the PLL in reset, waits for a stable
// lock with bounded retries, and releases the SoC only while the lock holds.
//
//   state        | meaning
//   POR_HOLD  0  | PLL held in reset after power-on / button reset
//   WAIT_LOCK 1  | PLL released, waiting for lock (with timeout)
//   STABLE    2  | lock seen, qualifying consecutive locked cycles
//   RUN       3  | SoC out of reset
//   RETRY     4  | PLL reset pulse before another lock attempt
//   FAULT     5  | retries exhausted, sticky until button reset
module soc_reset_sequencer
   import niosv_rst_seq_pkg::*;
#(
   parameter int unsigned POR_CYCLES          = DEF_POR_CYCLES,
   parameter int unsigned ARESET_CYCLES       = DEF_ARESET_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic       EXT_CLK_50MHz,
   input  logic       BTN_RESET_n,
   input  logic       pll_locked,
   input  logic       sw_reset_req,
   output logic       pll_areset,
   output logic       soc_reset_n,
   output logic [2:0] seq_state,
   output logic       lock_fault,
   output logic [1:0] retry_cnt
);

   localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);
   localparam int unsigned AR_W  = $clog2(ARESET_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [POR_W-1:0] POR_MAX   = POR_W'(POR_CYCLES);
   localparam logic [AR_W-1:0]  AR_MAX    = AR_W'(ARESET_CYCLES);
   localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [STB_W-1:0] STB_MAX   = STB_W'(LOCK_STABLE_CYCLES);
   localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

   logic rst_sync_n;
   logic lock_s;
   logic req_s;

   rst_seq_sync2 u_sync_rst  (.clk(EXT_CLK_50MHz), .rst_n(BTN_RESET_n), .d(1'b1),         .q(rst_sync_n));
   rst_seq_sync2 u_sync_lock (.clk(EXT_CLK_50MHz), .rst_n(rst_sync_n),  .d(pll_locked),   .q(lock_s));
   rst_seq_sync2 u_sync_req  (.clk(EXT_CLK_50MHz), .rst_n(rst_sync_n),  .d(sw_reset_req), .q(req_s));

   seq_state_e       state_q, state_d;
   logic [1:0]       retry_q, retry_d;
   logic [POR_W-1:0] por_cnt_q, por_cnt_d, por_inc;
   logic [AR_W-1:0]  ar_cnt_q, ar_cnt_d, ar_inc;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
   logic [STB_W-1:0] stb_cnt_q, stb_cnt_d, stb_inc;
   logic             req_prev_q, req_prev_d;
   logic             req_rise;

   // Each increment is the cycle count including the current cycle, saturating at its limit.
   assign por_inc  = (por_cnt_q == POR_MAX) ? por_cnt_q : por_cnt_q + POR_W'(1);
   assign ar_inc   = (ar_cnt_q  == AR_MAX)  ? ar_cnt_q  : ar_cnt_q  + AR_W'(1);
   assign tmo_inc  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
   assign stb_inc  = (stb_cnt_q == STB_MAX) ? stb_cnt_q : stb_cnt_q + STB_W'(1);
   assign req_rise = req_s & ~req_prev_q;

   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      por_cnt_d  = '0;
      ar_cnt_d   = '0;
      tmo_cnt_d  = '0;
      stb_cnt_d  = '0;
      req_prev_d = req_s;
      case (state_q)
         ST_POR_HOLD: begin
            if (por_inc == POR_MAX) state_d = ST_WAIT_LOCK;
            else                    por_cnt_d = por_inc;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (tmo_inc == TMO_MAX) begin
               if (retry_q < RETRY_MAX) begin
                  state_d = ST_RETRY;
                  retry_d = retry_q + 2'd1;
               end else begin
                  state_d = ST_FAULT;
               end
            end else begin
               tmo_cnt_d = tmo_inc;
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (stb_inc == STB_MAX) begin
               state_d = ST_RUN;
               retry_d = '0;
            end else begin
               stb_cnt_d = stb_inc;
            end
         end
         ST_RUN: begin
            if (!lock_s || req_rise) state_d = ST_RETRY;
         end
         ST_RETRY: begin
            if (ar_inc == AR_MAX) state_d = ST_WAIT_LOCK;
            else                  ar_cnt_d = ar_inc;
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_POR_HOLD;
      endcase
   end

   always_ff @(posedge EXT_CLK_50MHz or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q    <= ST_POR_HOLD;
         retry_q    <= '0;
         por_cnt_q  <= '0;
         ar_cnt_q   <= '0;
         tmo_cnt_q  <= '0;
         stb_cnt_q  <= '0;
         req_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         retry_q    <= retry_d;
         por_cnt_q  <= por_cnt_d;
         ar_cnt_q   <= ar_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         stb_cnt_q  <= stb_cnt_d;
         req_prev_q <= req_prev_d;
      end
   end

   assign pll_areset  = (state_q == ST_POR_HOLD) || (state_q == ST_RETRY) || (state_q == ST_FAULT);
   assign soc_reset_n = (state_q == ST_RUN);
   assign lock_fault  = (state_q == ST_FAULT);
   assign seq_state   = state_q;
   assign retry_cnt   = retry_q;

endmodule
